alarm_mode_ctrl: RTL and testbench
==================================

Name: alarm_mode_ctrl

Overview:
- Mode and alarm sequencer for the alarm clock.
- Owns the debounced buttons and turns them into one-cycle increment pulses, steered to either the time counters or the alarm-setup counters.
- Drives the display mux select and set-mode blink.
- Runs the ring/snooze/off sequence from the alarm-equals-time comparator.
- Sits between the debouncers and the time/alarm counters, display mux and buzzer.

Parameters:
- IDLE_SEG, 10: seconds without a button press before a set mode auto-exits to NORMAL.
- RING_SEG, 60: seconds of ringing before auto-stop.
- SNOOZE_SEG, 540: snooze length in seconds.
- All parameters are ≤ 1023; the second counter is 10 bits.

Ports:
- clk  in  1  FPGA system clock.
- rst  in  1  synchronous, active-high reset.
- tick_seg  in  1  one-clk pulse per second.
- btn_modo  in  1  debounced level, mode button.
- btn_hor  in  1  debounced level, hour button.
- btn_min  in  1  debounced level, minute button.
- btn_off  in  1  debounced level, alarm off / arm button.
- match  in  1  level; alarm time equals clock time.
- inc_hor_reloj  out  1  one-clk pulse, clock hours +1.
- inc_min_reloj  out  1  one-clk pulse, clock minutes +1.
- inc_hor_alam  out  1  one-clk pulse, alarm hours +1.
- inc_min_alam  out  1  one-clk pulse, alarm minutes +1.
- sel_alarma  out  1  display mux select; 1 = alarm digits.
- blink  out  1  display blank request.
- sonido  out  1  buzzer drive.
- armed  out  1  alarm enabled.
- estado  out  3  current state, for debug LEDs.

Behaviour:
- Single clock domain. Every synchronous element, the reset and all timing are on clk. rst is synchronous and active-high.
- All outputs are registered.
- Reset values:
  - state = NORMAL; armed = 0; all inc_* = 0; sonido = 0; blink = 0; sel_alarma = 0.
  - Second counter = 0; beep phase = 0; match_q = 1.
  - Button history registers load 1, so a button held through reset is not a press.
- Press detection: press = level & ~prev, where prev is registered each clk.
- Latency: an input rise at clk n gives an output effect (inc pulse or state change) at clk n+1.
- States (estado encoding): NORMAL=0, SET_RELOJ=1, SET_ALARMA=2, SONANDO=3, POSPUESTO=4.
- NORMAL:
  - modo press → SET_RELOJ.
  - off press toggles armed.
  - armed & match rising (match & ~match_q) → SONANDO, second counter cleared.
  - hor/min presses ignored.
- SET_RELOJ:
  - hor/min press → inc_hor_reloj / inc_min_reloj pulse.
  - modo press → SET_ALARMA.
- SET_ALARMA:
  - hor/min press → inc_hor_alam / inc_min_alam pulse.
  - modo press → NORMAL.
- Set-mode timeout: in either set mode, any press clears the second counter; the counter increments on tick_seg. When it reaches IDLE_SEG → NORMAL.
- Set-mode rules:
  - Presses of hor and min in the same clk both produce pulses.
  - match is ignored in set modes. A rising match while in a set mode is lost; no deferred ring.
  - off press in a set mode is ignored.
- SONANDO:
  - The phase bit toggles on tick_seg; sonido = phase.
  - Exit priority: off press → NORMAL (armed stays 1), then hor or min press → POSPUESTO, then counter reaching RING_SEG → NORMAL.
  - modo ignored.
  - On entering SONANDO, phase is set to 1.
- POSPUESTO:
  - sonido = 0.
  - off press → NORMAL.
  - Counter reaching SNOOZE_SEG → SONANDO, counter cleared.
- Counter rules:
  - The counter is cleared on every state change.
  - A press and tick_seg in the same clk: the clear wins.
  - The counter saturates and never wraps.
- sel_alarma = 1 only in SET_ALARMA.
- blink = phase in SET_RELOJ/SET_ALARMA, 0 elsewhere. The phase toggles on tick_seg in all states.
- Mid-operation rst: the next clk shows all reset values. Counters are not touched, and no pulse is emitted.
- After off in SONANDO, the same-minute match level does not re-trigger, because a rising edge is required.

Decomposition:
- Shared package holds:
  - State encoding constants ST_NORMAL…ST_POSPUESTO, width 3.
  - Default timing constants (IDLE_SEG, RING_SEG, SNOOZE_SEG).
  - Counter width 10.
- One natural sub-module: pulso_flanco, a registered rising-edge detector with reset-to-1 history. It is instantiated 4× for the buttons and once for match.

Test Plan (sim params IDLE_SEG=3, RING_SEG=4, SNOOZE_SEG=2; tick_seg every 10 clk):
- Reset held with btn_hor=1, then released → no inc pulse; estado=0, armed=0, sonido=0.
- modo press; 2 min presses; modo press; 1 hor press; modo press → exactly 2 inc_min_reloj and 1 inc_hor_alam pulses, each 1 clk wide, one clk after the press. estado goes 1,2,0; sel_alarma=1 only while estado=2.
- Enter SET_RELOJ, no presses for 3 ticks → estado=0 after the 3rd tick. Repeat with a press at tick 2 → still in SET_RELOJ at tick 4.
- off press (armed=1), raise match → estado=3 next clk, sonido toggles per tick. No press → estado=0 after 4 ticks. match held high → no re-ring.
- Ringing, min press → estado=4, sonido=0; after 2 ticks estado=3. Off press and hor press in the same clk → estado=0, armed=1.
- match rises while estado=1, then modo, modo → estado ends at 0, sonido stays 0.

Source files
------------

// File: rtl/alarm_mode_ctrl_pkg.sv
// Shared state encoding, counter width and timing defaults for the alarm mode sequencer.
package alarm_mode_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_NORMAL     = 3'd0,
        ST_SET_RELOJ  = 3'd1,
        ST_SET_ALARMA = 3'd2,
        ST_SONANDO    = 3'd3,
        ST_POSPUESTO  = 3'd4
    } state_t;

    localparam int CNT_W          = 10;
    localparam int DEF_IDLE_SEG   = 10;
    localparam int DEF_RING_SEG   = 60;
    localparam int DEF_SNOOZE_SEG = 540;

    // Second counter holds at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/alarm_mode_ctrl_pulso_flanco.sv
// Rising-edge detector: pulso is high while d is high and was low on the previous clk.
// History resets to 1 so a level held through reset never reads as an edge.
module pulso_flanco (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic pulso
);

    logic prev_q;

    always_ff @(posedge clk) begin
        if (rst) prev_q <= 1'b1;
        else     prev_q <= d;
    end

    assign pulso = d & ~prev_q;

endmodule

// File: rtl/alarm_mode_ctrl.sv
// Mode/alarm sequencer: button edges become steered increment pulses, plus ring/snooze/off control.
// One clk from an input edge to its registered effect; no backpressure, every pulse is one clk wide.
module alarm_mode_ctrl
    import alarm_mode_ctrl_pkg::*;
#(
    parameter int IDLE_SEG   = DEF_IDLE_SEG,
    parameter int RING_SEG   = DEF_RING_SEG,
    parameter int SNOOZE_SEG = DEF_SNOOZE_SEG
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_seg,
    input  logic       btn_modo,
    input  logic       btn_hor,
    input  logic       btn_min,
    input  logic       btn_off,
    input  logic       match,
    output logic       inc_hor_reloj,
    output logic       inc_min_reloj,
    output logic       inc_hor_alam,
    output logic       inc_min_alam,
    output logic       sel_alarma,
    output logic       blink,
    output logic       sonido,
    output logic       armed,
    output logic [2:0] estado
);

    localparam logic [CNT_W-1:0] IDLE_LIM   = CNT_W'(IDLE_SEG);
    localparam logic [CNT_W-1:0] RING_LIM   = CNT_W'(RING_SEG);
    localparam logic [CNT_W-1:0] SNOOZE_LIM = CNT_W'(SNOOZE_SEG);

    logic p_modo, p_hor, p_min, p_off, m_rise;

    pulso_flanco u_modo  (.clk(clk), .rst(rst), .d(btn_modo), .pulso(p_modo));
    pulso_flanco u_hor   (.clk(clk), .rst(rst), .d(btn_hor),  .pulso(p_hor));
    pulso_flanco u_min   (.clk(clk), .rst(rst), .d(btn_min),  .pulso(p_min));
    pulso_flanco u_off   (.clk(clk), .rst(rst), .d(btn_off),  .pulso(p_off));
    pulso_flanco u_match (.clk(clk), .rst(rst), .d(match),    .pulso(m_rise));

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             phase_q, phase_d;
    logic             armed_q, armed_d;
    logic             clr;
    logic             ihr_d, imr_d, iha_d, ima_d;

    always_comb begin
        state_d = state_q;
        armed_d = armed_q;
        cnt_inc = tick_seg ? sat_inc(cnt_q) : cnt_q;
        phase_d = phase_q ^ tick_seg;
        clr     = 1'b0;
        ihr_d   = 1'b0;
        imr_d   = 1'b0;
        iha_d   = 1'b0;
        ima_d   = 1'b0;
        case (state_q)
            ST_NORMAL: begin
                if (p_off) armed_d = ~armed_q;
                if (p_modo)                         state_d = ST_SET_RELOJ;
                else if (armed_q && m_rise && !p_off) state_d = ST_SONANDO;
            end
            ST_SET_RELOJ, ST_SET_ALARMA: begin
                clr = p_modo | p_hor | p_min;
                if (state_q == ST_SET_RELOJ) begin
                    ihr_d = p_hor;
                    imr_d = p_min;
                end else begin
                    iha_d = p_hor;
                    ima_d = p_min;
                end
                if (p_modo) begin
                    if (state_q == ST_SET_RELOJ) state_d = ST_SET_ALARMA;
                    else                         state_d = ST_NORMAL;
                end else if (!clr && cnt_inc >= IDLE_LIM) begin
                    state_d = ST_NORMAL;
                end
            end
            ST_SONANDO: begin
                if (p_off)                    state_d = ST_NORMAL;
                else if (p_hor || p_min)      state_d = ST_POSPUESTO;
                else if (cnt_inc >= RING_LIM) state_d = ST_NORMAL;
            end
            ST_POSPUESTO: begin
                if (p_off)                      state_d = ST_NORMAL;
                else if (cnt_inc >= SNOOZE_LIM) state_d = ST_SONANDO;
            end
            default: state_d = ST_NORMAL;
        endcase
        // Any state change restarts the second count; a press in the same clk as a tick wins too.
        if (state_d != state_q) begin
            cnt_d = '0;
            if (state_d == ST_SONANDO) phase_d = 1'b1;
        end else begin
            cnt_d = clr ? '0 : cnt_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_NORMAL;
            cnt_q         <= '0;
            phase_q       <= 1'b0;
            armed_q       <= 1'b0;
            inc_hor_reloj <= 1'b0;
            inc_min_reloj <= 1'b0;
            inc_hor_alam  <= 1'b0;
            inc_min_alam  <= 1'b0;
            sel_alarma    <= 1'b0;
            blink         <= 1'b0;
            sonido        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            phase_q       <= phase_d;
            armed_q       <= armed_d;
            inc_hor_reloj <= ihr_d;
            inc_min_reloj <= imr_d;
            inc_hor_alam  <= iha_d;
            inc_min_alam  <= ima_d;
            sel_alarma    <= (state_d == ST_SET_ALARMA);
            blink         <= ((state_d == ST_SET_RELOJ) || (state_d == ST_SET_ALARMA)) && phase_d;
            sonido        <= (state_d == ST_SONANDO) && phase_d;
        end
    end

    assign armed  = armed_q;
    assign estado = state_q;

endmodule

// File: tb/tb_alarm_mode_ctrl.sv
// Directed bench for alarm_mode_ctrl with an event/tick-count reference model compared every cycle.
module tb_alarm_mode_ctrl;

    localparam int IDLE   = 3;
    localparam int RING   = 4;
    localparam int SNOOZE = 2;

    localparam int M_NORMAL = 0;
    localparam int M_SETR   = 1;
    localparam int M_SETA   = 2;
    localparam int M_RING   = 3;
    localparam int M_SNZ    = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tick_seg = 1'b0;
    logic btn_modo = 1'b0, btn_hor = 1'b0, btn_min = 1'b0, btn_off = 1'b0, match = 1'b0;
    logic inc_hor_reloj, inc_min_reloj, inc_hor_alam, inc_min_alam;
    logic sel_alarma, blink, sonido, armed;
    logic [2:0] estado;

    int vectors = 0;
    int miscompares = 0;

    alarm_mode_ctrl #(
        .IDLE_SEG(IDLE), .RING_SEG(RING), .SNOOZE_SEG(SNOOZE)
    ) dut (
        .clk(clk), .rst(rst), .tick_seg(tick_seg),
        .btn_modo(btn_modo), .btn_hor(btn_hor), .btn_min(btn_min), .btn_off(btn_off),
        .match(match),
        .inc_hor_reloj(inc_hor_reloj), .inc_min_reloj(inc_min_reloj),
        .inc_hor_alam(inc_hor_alam), .inc_min_alam(inc_min_alam),
        .sel_alarma(sel_alarma), .blink(blink), .sonido(sonido),
        .armed(armed), .estado(estado)
    );

    always #5 clk = ~clk;

    // One tick_seg pulse every 10 clk.
    int cyc = 0;
    initial forever begin
        @(negedge clk);
        cyc++;
        tick_seg = (cyc % 10 == 0);
    end

    // Reference model: mode plus tick-count anchors for elapsed seconds and the blink/beep phase.
    int  m_mode, m_gt, m_anchor, m_ph_anchor, nm, el;
    bit  m_armed, m_ph_base, m_live = 1'b0;
    bit  pv_modo, pv_hor, pv_min, pv_off, pv_match;
    bit  pm, ph, pn, pf, rise, poke, phase;
    logic [3:0]  inc;
    logic [10:0] exp_v;
    wire  [10:0] act_v = {inc_hor_reloj, inc_min_reloj, inc_hor_alam, inc_min_alam,
                          sel_alarma, blink, sonido, armed, estado};

    always @(posedge clk) begin
        if (rst) begin
            m_mode = M_NORMAL; m_armed = 0; m_gt = 0; m_anchor = 0;
            m_ph_anchor = 0; m_ph_base = 0;
            pv_modo = 1; pv_hor = 1; pv_min = 1; pv_off = 1; pv_match = 1;
            exp_v = '0;
            m_live = 1;
        end else begin
            pm = btn_modo && !pv_modo; ph = btn_hor && !pv_hor; pn = btn_min && !pv_min;
            pf = btn_off && !pv_off;   rise = match && !pv_match;
            pv_modo = btn_modo; pv_hor = btn_hor; pv_min = btn_min; pv_off = btn_off; pv_match = match;
            if (tick_seg) m_gt++;
            el = m_gt - m_anchor;
            if (el > 1023) el = 1023;
            nm = m_mode; inc = 4'b0000; poke = 0;
            if (m_mode == M_NORMAL) begin
                if (pf) m_armed = !m_armed;
                if (pm) nm = M_SETR;
                else if (!pf && m_armed && rise) nm = M_RING;
            end else if (m_mode == M_SETR || m_mode == M_SETA) begin
                poke = pm || ph || pn;
                inc  = (m_mode == M_SETR) ? {ph, pn, 2'b00} : {2'b00, ph, pn};
                if (pm) nm = (m_mode == M_SETR) ? M_SETA : M_NORMAL;
                else if (!poke && el >= IDLE) nm = M_NORMAL;
            end else if (m_mode == M_RING) begin
                if (pf) nm = M_NORMAL;
                else if (ph || pn) nm = M_SNZ;
                else if (el >= RING) nm = M_NORMAL;
            end else begin
                if (pf) nm = M_NORMAL;
                else if (el >= SNOOZE) nm = M_RING;
            end
            if (nm != m_mode || poke) m_anchor = m_gt;
            if (nm == M_RING && m_mode != M_RING) begin
                m_ph_anchor = m_gt;
                m_ph_base   = 1;
            end
            m_mode = nm;
            phase  = m_ph_base ^ (((m_gt - m_ph_anchor) % 2) != 0);
            exp_v  = {inc, m_mode == M_SETA, (m_mode == M_SETR || m_mode == M_SETA) && phase,
                      m_mode == M_RING && phase, m_armed, 3'(m_mode)};
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            vectors++;
            if (act_v !== exp_v) begin
                miscompares++;
                $display("FAIL per_cycle t=%0t dut=%b model=%b", $time, act_v, exp_v);
            end
        end
    end

    // Output pulse/high-cycle counters, sampled just after each active edge.
    int ihr_cnt = 0, imr_cnt = 0, iha_cnt = 0, ima_cnt = 0, son_cnt = 0;
    initial forever begin
        @(posedge clk);
        #1;
        if (inc_hor_reloj) ihr_cnt++;
        if (inc_min_reloj) imr_cnt++;
        if (inc_hor_alam)  iha_cnt++;
        if (inc_min_alam)  ima_cnt++;
        if (sonido)        son_cnt++;
    end

    task automatic chk(input string name, input int act, input int expv);
        vectors++;
        if (act != expv) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    task automatic press(input bit m, input bit h, input bit n, input bit f);
        @(negedge clk);
        btn_modo = m; btn_hor = h; btn_min = n; btn_off = f;
        @(negedge clk);
        btn_modo = 0; btn_hor = 0; btn_min = 0; btn_off = 0;
    endtask

    task automatic wait_ticks(input int n);
        for (int k = 0; k < n; k++) begin
            int guard;
            guard = 0;
            do begin
                @(posedge clk);
                guard++;
            end while (!tick_seg && guard < 15);
            if (!tick_seg) begin
                vectors++;
                miscompares++;
                $display("FAIL tick_wait: got no tick in %0d clk, expected one", guard);
            end
        end
    endtask

    int b_son;

    initial begin
        // Reset with hour button held through it.
        rst = 1; btn_hor = 1;
        repeat (3) @(negedge clk);
        chk("rst_estado", int'(estado), 0);
        chk("rst_armed", int'(armed), 0);
        chk("rst_sonido", int'(sonido), 0);
        chk("rst_sel", int'(sel_alarma), 0);
        rst = 0;
        repeat (5) @(negedge clk);
        chk("held_no_pulse", ihr_cnt + imr_cnt + iha_cnt + ima_cnt, 0);
        btn_hor = 0;
        @(negedge clk);

        // Set clock minutes twice, alarm hour once.
        press(1, 0, 0, 0); chk("to_set_reloj", int'(estado), 1);
        press(0, 0, 1, 0); chk("min_pulse_now", int'(inc_min_reloj), 1);
        @(negedge clk);    chk("min_pulse_1clk", int'(inc_min_reloj), 0);
        press(0, 0, 1, 0);
        press(1, 0, 0, 0); chk("to_set_alarma", int'(estado), 2);
        chk("sel_in_alarma", int'(sel_alarma), 1);
        press(0, 1, 0, 0); chk("hor_alam_now", int'(inc_hor_alam), 1);
        press(1, 0, 0, 0); chk("back_normal", int'(estado), 0);
        chk("sel_in_normal", int'(sel_alarma), 0);
        @(negedge clk);
        chk("n_min_reloj", imr_cnt, 2);
        chk("n_hor_alam", iha_cnt, 1);
        chk("n_hor_reloj", ihr_cnt, 0);
        chk("n_min_alam", ima_cnt, 0);

        // Idle timeout, then a press restarting it.
        press(1, 0, 0, 0); chk("idle_enter", int'(estado), 1);
        wait_ticks(2); #1; chk("idle_2ticks", int'(estado), 1);
        wait_ticks(1); #1; chk("idle_timeout", int'(estado), 0);
        press(1, 0, 0, 0); chk("idle2_enter", int'(estado), 1);
        wait_ticks(2);
        press(0, 1, 0, 0);
        wait_ticks(2); #1; chk("press_restarts", int'(estado), 1);
        wait_ticks(1); #1; chk("timeout_after_press", int'(estado), 0);

        // Arm, ring, auto-stop, no re-ring on held match.
        press(0, 0, 0, 1); chk("off_arms", int'(armed), 1);
        @(negedge clk); match = 1;
        @(negedge clk);
        chk("ring_enter", int'(estado), 3);
        chk("ring_sonido_on", int'(sonido), 1);
        wait_ticks(1); #1; chk("ring_toggle", int'(sonido), 0);
        wait_ticks(2); #1; chk("ring_3ticks", int'(estado), 3);
        wait_ticks(1); #1; chk("ring_autostop", int'(estado), 0);
        chk("autostop_quiet", int'(sonido), 0);
        chk("autostop_armed", int'(armed), 1);
        repeat (25) @(negedge clk);
        chk("no_rering", int'(estado), 0);
        match = 0;

        // Snooze, re-ring, then off and hour together.
        @(negedge clk); match = 1;
        @(negedge clk); chk("ring2_enter", int'(estado), 3);
        press(0, 0, 1, 0); chk("snooze_enter", int'(estado), 4);
        chk("snooze_quiet", int'(sonido), 0);
        wait_ticks(1); #1; chk("snooze_1tick", int'(estado), 4);
        wait_ticks(1); #1; chk("snooze_end", int'(estado), 3);
        chk("re_ring_sonido", int'(sonido), 1);
        press(0, 1, 0, 1); chk("off_beats_hor", int'(estado), 0);
        chk("armed_kept", int'(armed), 1);

        // Match rising in a set mode is lost.
        match = 0;
        press(1, 0, 0, 0); chk("set_enter", int'(estado), 1);
        b_son = son_cnt;
        @(negedge clk); match = 1;
        repeat (3) @(negedge clk);
        chk("set_ignores_match", int'(estado), 1);
        press(1, 0, 0, 0);
        press(1, 0, 0, 0); chk("set_exit", int'(estado), 0);
        repeat (15) @(negedge clk);
        chk("no_deferred_ring", int'(estado), 0);
        chk("never_sounded", son_cnt - b_son, 0);
        match = 0;

        // Reset mid-operation with a press in the same clk.
        press(1, 0, 0, 0); chk("pre_rst_set", int'(estado), 1);
        @(negedge clk); btn_min = 1; rst = 1;
        @(negedge clk);
        chk("rst_no_pulse", int'(inc_min_reloj), 0);
        chk("rst_mid_estado", int'(estado), 0);
        chk("rst_mid_armed", int'(armed), 0);
        chk("rst_mid_blink", int'(blink), 0);
        rst = 0; btn_min = 0;
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish by t=%0t, expected finish", $time);
        $fatal(1, "watchdog");
    end

endmodule
